// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Registered ALU for the multicycle datapath. Logic and arithmetic ops
//   finish one edge after acceptance. Shifts are iterative, one bit per
//   edge. A start/busy/done handshake lets the controller wait on the
//   variable-latency shift ops.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, sampled only while busy=0
//   op[3:0]   operation select
//   a, b      operands. b[SHW-1:0] is the shift amount for shifts.
//   result    registered result, held until the next completion
//   zero      combinational (result == 0)
//   overflow  registered signed overflow of the last ADD/SUB, else 0
//   busy      high while an accepted op is in flight
//   done      one-cycle pulse when result/overflow are updated
// ---------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_op;
    logic signed [WIDTH-1:0] r_a;
    logic signed [WIDTH-1:0] r_b;
    logic [WIDTH-1:0]        r_work;
    logic [SHW-1:0]          r_cnt;
    logic [WIDTH-1:0]        r_result;
    logic                    r_overflow;
    logic                    r_done;

    logic                    w_accept;
    logic                    w_shift_step;
    logic                    w_write;
    logic                    w_done_nxt;
    logic [WIDTH-1:0]        w_result_nxt;
    logic                    w_overflow_nxt;

    function automatic logic is_shift(input logic [3:0] f_op);
        return (f_op == OP_SLL) || (f_op == OP_SRL) || (f_op == OP_SRA);
    endfunction

    // Single-cycle ops. Illegal codes produce 0.
    function automatic logic [WIDTH-1:0] alu_result(
        input logic [3:0]              f_op,
        input logic signed [WIDTH-1:0] f_a,
        input logic signed [WIDTH-1:0] f_b
    );
        logic [WIDTH-1:0] res;
        case (f_op)
            OP_AND:  res = f_a & f_b;
            OP_OR:   res = f_a | f_b;
            OP_ADD:  res = f_a + f_b;
            OP_SUB:  res = f_a - f_b;
            // True signed compare, independent of subtraction overflow
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, (f_a < f_b)};
            OP_NOR:  res = ~(f_a | f_b);
            default: res = '0;
        endcase
        return res;
    endfunction

    // Overflow: the operand signs allow it, and the result sign differs from a.
    function automatic logic alu_overflow(
        input logic [3:0]              f_op,
        input logic signed [WIDTH-1:0] f_a,
        input logic signed [WIDTH-1:0] f_b
    );
        logic signed [WIDTH-1:0] sum;
        logic signed [WIDTH-1:0] diff;
        logic                    ovf;
        sum  = f_a + f_b;
        diff = f_a - f_b;
        case (f_op)
            OP_ADD:  ovf = (f_a[WIDTH-1] == f_b[WIDTH-1]) && (sum[WIDTH-1]  != f_a[WIDTH-1]);
            OP_SUB:  ovf = (f_a[WIDTH-1] != f_b[WIDTH-1]) && (diff[WIDTH-1] != f_a[WIDTH-1]);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

    function automatic logic [WIDTH-1:0] shift1(
        input logic [3:0]       f_op,
        input logic [WIDTH-1:0] f_v
    );
        logic [WIDTH-1:0] res;
        case (f_op)
            OP_SLL:  res = {f_v[WIDTH-2:0], 1'b0};
            OP_SRA:  res = {f_v[WIDTH-1], f_v[WIDTH-1:1]};
            default: res = {1'b0, f_v[WIDTH-1:1]};
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_shift_step   = 1'b0;
        w_write        = 1'b0;
        w_done_nxt     = 1'b0;
        w_result_nxt   = r_result;
        w_overflow_nxt = r_overflow;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = is_shift(op) ? S_SHIFT : S_EXEC;
                end
            end
            S_EXEC: begin
                w_write        = 1'b1;
                w_done_nxt     = 1'b1;
                w_result_nxt   = alu_result(r_op, r_a, r_b);
                w_overflow_nxt = alu_overflow(r_op, r_a, r_b);
                w_state_nxt    = S_IDLE;
            end
            S_SHIFT: begin
                if (r_cnt != '0) begin
                    w_shift_step = 1'b1;
                end else begin
                    w_write        = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_result_nxt   = r_work;
                    w_overflow_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_write) begin
                r_result   <= w_result_nxt;
                r_overflow <= w_overflow_nxt;
            end
            if (w_accept) begin
                r_op   <= op;
                r_a    <= a;
                r_b    <= b;
                r_work <= a;
                r_cnt  <= b[SHW-1:0];
            end else if (w_shift_step) begin
                r_work <= shift1(r_op, r_work);
                r_cnt  <= r_cnt - SHW'(1);
            end
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;
    assign done     = r_done;
    // busy drops in the same cycle done rises, so the two never overlap
    assign busy     = (r_state != S_IDLE);
    assign zero     = (r_result == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive a request for one edge, then scramble the operand inputs to
    // show only the latched copies matter. Returns 1 ns after accept.
    task automatic issue(input logic [3:0] i_op, input logic [31:0] i_a, input logic [31:0] i_b);
        @(negedge clk);
        start = 1'b1;
        op    = i_op;
        a     = i_a;
        b     = i_b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 4'(($urandom));
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Count edges until done is seen, with a bound.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("busy_low_in_done", 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.op, v.a, v.b);
        wait_done(lat);
        check({v.name, "_lat"}, 32'(lat), 32'(v.lat));
        check({v.name, "_res"}, result, v.res);
        check({v.name, "_ovf"}, 32'(overflow), 32'(v.ovf));
        check({v.name, "_zero"}, 32'(zero), 32'(v.res == 32'd0));
    endtask

    initial begin
        int lat;
        n_tests = 0;
        n_fail  = 0;

        vecs.push_back('{"add_ovf",   OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1});
        vecs.push_back('{"sub_zero",  OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1});
        vecs.push_back('{"add_ovf2",  OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1});
        vecs.push_back('{"sll_clr",   OP_SLL, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 5});
        vecs.push_back('{"add_carry", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1});
        vecs.push_back('{"sub_ovf",   OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1});
        vecs.push_back('{"slt_neg",   OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1});
        vecs.push_back('{"slt_ext",   OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1});
        vecs.push_back('{"slt_false", OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1});
        vecs.push_back('{"and",       OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1});
        vecs.push_back('{"or",        OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1});
        vecs.push_back('{"nor",       OP_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1});
        vecs.push_back('{"sra_31",    OP_SRA, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 32});
        vecs.push_back('{"sll_0",     OP_SLL, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1});
        vecs.push_back('{"srl_4",     OP_SRL, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 5});
        vecs.push_back('{"sra_pos",   OP_SRA, 32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0, 5});
        vecs.push_back('{"sll_hib",   OP_SLL, 32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 4});
        vecs.push_back('{"illegal",   4'b0011, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1});

        // Reset, with start held high: nothing may be accepted
        rst_n = 1'b0;
        start = 1'b1;
        op    = OP_ADD;
        a     = 32'd1;
        b     = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_result", result, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Start while busy is ignored; back-to-back issue in the done cycle
        issue(OP_SRL, 32'hFFFFFFFF, 32'd16);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("srl_busy_mid", 32'(busy), 32'd1);
        end
        @(negedge clk);
        start = 1'b1;
        op    = OP_ADD;
        a     = 32'd1;
        b     = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("srl_ign_lat", 32'(lat), 32'd13);
        check("srl_ign_res", result, 32'h0000FFFF);
        issue(OP_ADD, 32'd2, 32'd3);
        check("b2b_done_low", 32'(done), 32'd0);
        wait_done(lat);
        check("b2b_lat", 32'(lat), 32'd1);
        check("b2b_res", result, 32'd5);
        @(posedge clk);
        #1;
        check("done_pulse_once", 32'(done), 32'd0);

        // Asynchronous reset mid-shift aborts
        issue(OP_SLL, 32'd1, 32'd10);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_result", result, 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        issue(4'b1111, 32'h0000FFFF, 32'h00000001);
        wait_done(lat);
        check("ill_lat", 32'(lat), 32'd1);
        check("ill_res", result, 32'd0);
        check("ill_ovf", 32'(overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
